rom_link_codec: RTL and testbench

- Sits between the ROM bus frontend logic and the command/response byte FIFOs that cross into the ft_clk domain toward the FT232H bridge.
- Serializes one read request into a fixed command frame written byte-wise into the command FIFO.
- Consumes the response FIFO byte stream, checks framing, and assembles 64-bit little-endian beats for the bus side.
- Handles a single outstanding request at a time.

---
 rtl/rom_link_codec.sv | 181 ++++++++++++++++++
 tb/tb_rom_link_codec.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_link_codec.sv
// Read-request codec between the ROM bus frontend and the FT232H command/response byte FIFOs.
// Optional build macro ROM_LINK_CSUM_EN: expect and verify a trailing XOR checksum byte per response.
module rom_link_codec #(
    parameter int         ADDR_W   = 32,
    parameter logic [7:0] SYNC_CMD = 8'hA5,
    parameter logic [7:0] SYNC_RSP = 8'h5A
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_len,
    input  logic              c_full,
    output logic              c_wr_en,
    output logic [7:0]        c_din,
    input  logic              r_empty,
    output logic              r_rd_en,
    input  logic [7:0]        r_dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_data,
    output logic              rsp_last,
    output logic              rsp_err
);
    localparam int FRAME_LEN = 3 + ADDR_W / 8;
    localparam int FRAME_W   = FRAME_LEN * 8;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RSP_SYNC,
        S_RSP_DATA,
        S_RSP_OUT,
        S_RSP_CSUM
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q;     // command frame, shifted out MSB byte first
    logic [IDX_W-1:0]   cmd_idx_q;
    logic [2:0]         byte_cnt_q;  // data bytes captured in the current beat
    logic [8:0]         beat_cnt_q;  // beats remaining, including the current one
    logic               rd_pend_q;   // a response read was issued last cycle
    logic               final_beat;
    logic               data_done;

    assign final_beat = (beat_cnt_q == 9'd1);
    assign data_done  = rd_pend_q && (byte_cnt_q == 3'd7);

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        c_wr_en   = 1'b0;
        c_din     = 8'h00;
        r_rd_en   = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = S_CMD;
            end
            S_CMD: begin
                c_din   = frame_q[FRAME_W-1 -: 8];
                c_wr_en = !c_full;
                if (!c_full && cmd_idx_q == LAST_IDX) state_d = S_RSP_SYNC;
            end
            S_RSP_SYNC: begin
                r_rd_en = !r_empty && !rd_pend_q;
                if (rd_pend_q) state_d = (r_dout == SYNC_RSP) ? S_RSP_DATA : S_RSP_OUT;
            end
            S_RSP_DATA: begin
                r_rd_en = !r_empty && !rd_pend_q;
                if (data_done) begin
`ifdef ROM_LINK_CSUM_EN
                    state_d = final_beat ? S_RSP_CSUM : S_RSP_OUT;
`else
                    state_d = S_RSP_OUT;
`endif
                end
            end
            S_RSP_OUT: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = rsp_last ? S_IDLE : S_RSP_DATA;
            end
            S_RSP_CSUM: begin
                r_rd_en = !r_empty && !rd_pend_q;
                if (rd_pend_q) state_d = S_RSP_OUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ROM_LINK_CSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 8'h00;
        end else if (state_q == S_IDLE && req_valid) begin
            csum_q <= 8'h00;
        end else if (state_q == S_RSP_DATA && rd_pend_q) begin
            csum_q <= csum_q ^ r_dout;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q    <= '0;
            cmd_idx_q  <= '0;
            byte_cnt_q <= '0;
            beat_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rsp_data   <= '0;
            rsp_last   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            rd_pend_q <= r_rd_en;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        frame_q    <= {SYNC_CMD, 8'h01, req_addr, req_len};
                        cmd_idx_q  <= '0;
                        byte_cnt_q <= '0;
                        beat_cnt_q <= {1'b0, req_len} + 9'd1;
                        rsp_last   <= 1'b0;
                        rsp_err    <= 1'b0;
                    end
                end
                S_CMD: begin
                    if (!c_full) begin
                        frame_q   <= frame_q << 8;
                        cmd_idx_q <= cmd_idx_q + 1'b1;
                    end
                end
                S_RSP_SYNC: begin
                    // A bad sync byte ends the request with a single error beat.
                    if (rd_pend_q && r_dout != SYNC_RSP) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        rsp_last <= 1'b1;
                    end
                end
                S_RSP_DATA: begin
                    if (rd_pend_q) begin
                        rsp_data   <= {r_dout, rsp_data[63:8]};
                        byte_cnt_q <= byte_cnt_q + 3'd1;
`ifndef ROM_LINK_CSUM_EN
                        if (byte_cnt_q == 3'd7 && final_beat) rsp_last <= 1'b1;
`endif
                    end
                end
                S_RSP_OUT: begin
                    if (rsp_ready && !rsp_last) beat_cnt_q <= beat_cnt_q - 9'd1;
                end
`ifdef ROM_LINK_CSUM_EN
                S_RSP_CSUM: begin
                    if (rd_pend_q) begin
                        rsp_err  <= (csum_q != r_dout);
                        rsp_last <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_link_codec.sv
// Bench for rom_link_codec: models both byte FIFOs and predicts frames and beats from the link rules.
`timescale 1ns/1ps
module tb_rom_link_codec;
    localparam int ADDR_W = 32;
    localparam int NB     = ADDR_W / 8;
`ifdef ROM_LINK_CSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_len;
    logic              c_full, c_wr_en;
    logic [7:0]        c_din;
    logic              r_empty, r_rd_en;
    logic [7:0]        r_dout;
    logic              rsp_valid, rsp_ready;
    logic [63:0]       rsp_data;
    logic              rsp_last, rsp_err;

    int total = 0;
    int bad   = 0;

    byte unsigned rsp_q[$];      // response FIFO contents
    byte unsigned rsp_bytes[$];  // response frame for the next request
    byte unsigned cmd_obs[$];    // bytes written to the command FIFO
    byte unsigned exp_cmd[$];
    int  pop_cnt    = 0;
    bit  cmd_active = 1'b0;
    bit  rd_prev    = 1'b0;
    bit  rd_seen    = 1'b0;
    int  full_after = -1;
    int  full_left  = 0;
    bit  rand_full  = 1'b0;
    bit  rand_empty = 1'b0;
    bit  rand_stall = 1'b0;

    always #5 clk = ~clk;

    rom_link_codec #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .c_full(c_full), .c_wr_en(c_wr_en), .c_din(c_din),
        .r_empty(r_empty), .r_rd_en(r_rd_en), .r_dout(r_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO models: response data appears the cycle after a read strobe, otherwise r_dout is noise.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rd_seen && rsp_q.size() > 0) begin
                r_dout = rsp_q.pop_front();
                pop_cnt++;
            end else begin
                r_dout = 8'($urandom);
            end
            if (full_left > 0 && cmd_obs.size() == full_after) begin
                c_full = 1'b1;
                full_left--;
            end else begin
                c_full = rand_full && ($urandom_range(0, 3) == 0);
            end
            r_empty = (rsp_q.size() == 0) || (rand_empty && $urandom_range(0, 2) == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("rd_back_to_back", rd_prev & r_rd_en, 1'b0);
                check("rd_while_empty", r_empty & r_rd_en, 1'b0);
                check("rd_while_valid", rsp_valid & r_rd_en, 1'b0);
                check("wr_while_full", c_full & c_wr_en, 1'b0);
                if (!cmd_active) check("wr_outside_cmd", c_wr_en, 1'b0);
                else if (c_full) check("cmd_hold", c_din, exp_cmd[cmd_obs.size()]);
                if (c_wr_en && !c_full) begin
                    cmd_obs.push_back(c_din);
                    if (cmd_obs.size() >= exp_cmd.size()) cmd_active = 1'b0;
                end
            end
            rd_prev = r_rd_en & rst_n;
            rd_seen = r_rd_en & rst_n;
        end
    end

    task automatic check_reset_values();
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_c_wr_en", c_wr_en, 1'b0);
        check("rst_c_din", c_din, 8'h00);
        check("rst_r_rd_en", r_rd_en, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 64'h0);
        check("rst_rsp_last", rsp_last, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
    endtask

    task automatic make_rsp(input int len, input bit sync_bad, input bit csum_bad);
        byte unsigned b;
        byte unsigned x;
        rsp_bytes.delete();
        if (sync_bad) begin
            do b = 8'($urandom); while (b == 8'h5A);
            rsp_bytes.push_back(b);
        end else begin
            rsp_bytes.push_back(8'h5A);
        end
        x = 8'h00;
        for (int i = 0; i < 8 * (len + 1); i++) begin
            b = 8'($urandom);
            x ^= b;
            rsp_bytes.push_back(b);
        end
        if (CSUM_BYTES == 1 && !sync_bad) rsp_bytes.push_back(csum_bad ? (x ^ 8'h01) : x);
    endtask

    task automatic add_csum();
        byte unsigned x;
        x = 8'h00;
        for (int i = 1; i < rsp_bytes.size(); i++) x ^= rsp_bytes[i];
        if (CSUM_BYTES == 1) rsp_bytes.push_back(x);
    endtask

    task automatic run_req(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                           input int stall_first, input int abort_at);
        logic [63:0] e_data[$];
        bit          e_last[$];
        bit          e_err[$];
        logic [63:0] d;
        byte unsigned x;
        int consumed;
        int beat;
        int stall;
        int cyc;
        int budget;
        beat   = 0;
        cyc    = 0;
        budget = 40 * (int'(len) + 1) + 200;

        if (rsp_bytes[0] != 8'h5A) begin
            e_data.push_back(64'h0);
            e_last.push_back(1'b1);
            e_err.push_back(1'b1);
            consumed = 1;
        end else begin
            x = 8'h00;
            for (int b = 0; b <= int'(len); b++) begin
                d = '0;
                for (int k = 0; k < 8; k++) begin
                    d[8*k +: 8] = rsp_bytes[1 + 8*b + k];
                    x ^= rsp_bytes[1 + 8*b + k];
                end
                e_data.push_back(d);
                e_last.push_back(b == int'(len));
                e_err.push_back(1'b0);
            end
            if (CSUM_BYTES == 1) e_err[int'(len)] = (x != rsp_bytes[1 + 8*(int'(len) + 1)]);
            consumed = 1 + 8 * (int'(len) + 1) + CSUM_BYTES;
        end

        exp_cmd.delete();
        cmd_obs.delete();
        exp_cmd.push_back(8'hA5);
        exp_cmd.push_back(8'h01);
        for (int i = NB - 1; i >= 0; i--) exp_cmd.push_back(addr[8*i +: 8]);
        exp_cmd.push_back(len);
        rsp_q   = rsp_bytes;
        pop_cnt = 0;

        req_addr  = addr;
        req_len   = len;
        req_valid = 1'b1;
        check("req_ready_idle", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        cmd_active = 1'b1;

        while (beat < e_data.size()) begin
            @(negedge clk);
            cyc++;
            if (abort_at >= 0 && pop_cnt >= abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_values();
                rsp_q.delete();
                cmd_active = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            if (cyc > budget) begin
                check("beat_timeout", beat, e_data.size());
                break;
            end
            if (rsp_valid) begin
                stall = (beat == 0) ? stall_first : (rand_stall ? $urandom_range(0, 2) : 0);
                for (int s = 0; s <= stall; s++) begin
                    if (s > 0) @(negedge clk);
                    check("rsp_valid", rsp_valid, 1'b1);
                    check("rsp_data", rsp_data, e_data[beat]);
                    check("rsp_last", rsp_last, e_last[beat]);
                    check("rsp_err", rsp_err, e_err[beat]);
                    check("req_ready_busy", req_ready, 1'b0);
                end
                rsp_ready = 1'b1;
                @(posedge clk);
                #1;
                rsp_ready = 1'b0;
                beat++;
            end
        end

        @(negedge clk);
        check("req_ready_after", req_ready, 1'b1);
        check("cmd_len", cmd_obs.size(), exp_cmd.size());
        for (int i = 0; i < exp_cmd.size() && i < cmd_obs.size(); i++)
            check($sformatf("cmd_byte%0d", i), cmd_obs[i], exp_cmd[i]);
        check("rsp_leftover", rsp_q.size(), rsp_bytes.size() - consumed);
        rsp_q.delete();
        cmd_active = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = 8'h00;
        c_full    = 1'b0;
        r_empty   = 1'b1;
        r_dout    = 8'h00;
        rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #10 check_reset_values();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single beat, known bytes
        rsp_bytes = '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        add_csum();
        run_req(32'h0000_1000, 8'd0, 0, -1);

        // Command FIFO full for 5 cycles after the third byte
        full_after = 3;
        full_left  = 5;
        run_req(32'h0000_1000, 8'd0, 0, -1);
        full_after = -1;

        // Two beats with the consumer stalled on the first
        make_rsp(1, 1'b0, 1'b0);
        run_req(32'hDEAD_BEEF, 8'd1, 10, -1);

        // Bad sync byte
        rsp_bytes = '{8'h3C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_req(32'h0000_0040, 8'd0, 0, -1);

`ifdef ROM_LINK_CSUM_EN
        rsp_bytes = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        run_req(32'h0000_2000, 8'd0, 0, -1);
        rsp_bytes = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        run_req(32'h0000_2000, 8'd0, 0, -1);
`endif

        // Reset in the middle of the data bytes, then a clean request
        make_rsp(3, 1'b0, 1'b0);
        run_req(32'h1234_5678, 8'd3, 0, 5);
        repeat (2) @(posedge clk);
        #1;
        make_rsp(0, 1'b0, 1'b0);
        run_req(32'h0000_0100, 8'd0, 0, -1);

        // Longest request: 256 beats
        make_rsp(255, 1'b0, 1'b0);
        run_req(32'hFFFF_FFF8, 8'd255, 0, -1);

        // Randomized traffic with FIFO and consumer back-pressure
        rand_full  = 1'b1;
        rand_empty = 1'b1;
        rand_stall = 1'b1;
        for (int t = 0; t < 30; t++) begin
            automatic int  len      = $urandom_range(0, 4);
            automatic bit  sync_bad = ($urandom_range(0, 9) == 0);
            automatic bit  csum_bad = ($urandom_range(0, 3) == 0);
            make_rsp(len, sync_bad, csum_bad);
            run_req(ADDR_W'($urandom), 8'(len), $urandom_range(0, 3), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
